// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS instruction requests into 32-bit words, tags each with a
// sequential byte address and buffers them in a small FIFO drained over valid/ready.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_kind,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [3:0] K_ADDU = 4'd0;
  localparam logic [3:0] K_SUBU = 4'd1;
  localparam logic [3:0] K_LW   = 4'd2;
  localparam logic [3:0] K_SW   = 4'd3;
  localparam logic [3:0] K_BEQ  = 4'd4;
  localparam logic [3:0] K_ORI  = 4'd5;
  localparam logic [3:0] K_LUI  = 4'd6;
  localparam logic [3:0] K_JAL  = 4'd7;

  logic [31:0]    mem_instr [DEPTH];
  logic [31:0]    mem_addr  [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [31:0]    next_addr;
  logic           rdy_en;

  logic [31:0]    enc_c;
  logic           illegal_c;
  logic           push_c, pop_c;
  logic [PW-1:0]  rptr_nxt_c;
  logic [CW-1:0]  count_nxt_c;
  logic [31:0]    head_instr_c, head_addr_c;

  // Instruction word formation from the request fields
  always_comb begin
    enc_c     = 32'h0000_0000;
    illegal_c = 1'b0;
    case (in_kind)
      K_ADDU:  enc_c = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
      K_SUBU:  enc_c = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
      K_LW:    enc_c = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:    enc_c = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ:   enc_c = {6'b000100, in_rs, in_rt, in_imm};
      K_ORI:   enc_c = {6'b001101, in_rs, in_rt, in_imm};
      K_LUI:   enc_c = {6'b001111, 5'b00000, in_rt, in_imm};
      K_JAL:   enc_c = {6'b000011, in_index};
      default: illegal_c = 1'b1;
    endcase
  end

  assign in_ready  = rdy_en && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Next head: the incoming word when the FIFO would otherwise be empty
  always_comb begin
    rptr_nxt_c  = pop_c ? rptr + PW'(1) : rptr;
    count_nxt_c = count + CW'(push_c) - CW'(pop_c);
    if (count == CW'(pop_c)) begin
      head_instr_c = enc_c;
      head_addr_c  = next_addr;
    end else begin
      head_instr_c = mem_instr[rptr_nxt_c];
      head_addr_c  = mem_addr[rptr_nxt_c];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_instr[wptr] <= enc_c;
      mem_addr[wptr]  <= next_addr;
    end
  end

  // Control state; output registers hold their last value once empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
      err       <= 1'b0;
      rdy_en    <= 1'b0;
      out_instr <= 32'h0000_0000;
      out_addr  <= 32'h0000_0000;
    end else begin
      rdy_en <= 1'b1;
      count  <= count_nxt_c;
      rptr   <= rptr_nxt_c;
      if (push_c) begin
        wptr      <= wptr + PW'(1);
        next_addr <= next_addr + 32'd4;
        if (illegal_c) err <= 1'b1;
      end
      if (count_nxt_c != '0) begin
        out_instr <= head_instr_c;
        out_addr  <= head_addr_c;
      end
    end
  end

endmodule
